mips_multicycle_control: RTL and testbench

Main control unit for the multicycle MIPS datapath. This is the producer side of the `OpALU` interface: it decodes the instruction opcode and sequences every instruction through fetch, decode, execute, memory and writeback. Each state drives the datapath strobes and the 2-bit `OpALU` code consumed by the ALU control stage. Memory accesses use a ready handshake, so the block stalls cleanly on slow memory.

---
 rtl/mips_multicycle_control.sv | 116 +++++++++++
 tb/tb_mips_multicycle_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: main control FSM of the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives strobes plus the OpALU code.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] OpALU,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADDR = 4'd2, S_MEMREAD = 4'd3, S_MEMWB = 4'd4,
    S_MEMWRITE = 4'd5, S_EXECUTE = 4'd6, S_RCOMPL = 4'd7, S_BRANCH = 4'd8, S_JUMP = 4'd9
  } state_t;
  state_t state_q, state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_FETCH;
    else state_q <= state_d;
  // Outputs are gated by rst_n so nothing fires while reset is held, even though FETCH is active.
  always_comb begin
    state_d = S_FETCH;
    OpALU = 2'b00;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    MemtoReg = 1'b0;
    RegDst = 1'b0;
    RegWrite = 1'b0;
    PCSource = 2'b00;
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    illegal_op = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          state_d = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADDR;
            OP_R:         state_d = S_EXECUTE;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            default:      illegal_op = 1'b1;
          endcase
        end
        S_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          MemRead = 1'b1;
          IorD = 1'b1;
          state_d = mem_ready ? S_MEMWB : S_MEMREAD;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWRITE: begin
          MemWrite = 1'b1;
          IorD = 1'b1;
          state_d = mem_ready ? S_FETCH : S_MEMWRITE;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          OpALU = 2'b10;
          state_d = S_RCOMPL;
        end
        S_RCOMPL: begin
          RegWrite = 1'b1;
          RegDst = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          OpALU = 2'b01;
          PCWriteCond = 1'b1;
          PCSource = 2'b01;
        end
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSource = 2'b10;
        end
        default: state_d = S_FETCH;
      endcase
    end
    pc_en = PCWrite | (PCWriteCond & zero);
  end
  assign state = state_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: randomized bench comparing the control FSM against a route-table model.
module tb_mips_multicycle_control;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [1:0] OpALU, ALUSrcB, PCSource;
  logic ALUSrcA, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
  logic PCWrite, PCWriteCond, pc_en, illegal_op;
  logic [3:0] state;
  logic [17:0] dut_out;
  int passed = 0, total = 0;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .OpALU(OpALU), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .PCSource(PCSource), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .pc_en(pc_en), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;
  assign dut_out = {OpALU, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    RegDst, RegWrite, PCSource, PCWrite, PCWriteCond, pc_en, illegal_op};

  // Expected output vector for one state, taken straight from the per-state strobe table.
  function automatic logic [17:0] exp_out(int s, logic mr, logic z, logic [5:0] opc);
    logic [1:0] op, srcb, pcs;
    logic srca, iord, mrd, mwr, irw, m2r, rdst, rw, pcw, pcwc, ill;
    {op, srcb, pcs} = '0;
    {srca, iord, mrd, mwr, irw, m2r, rdst, rw, pcw, pcwc, ill} = '0;
    case (s)
      0: begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      1: begin srcb = 2'b11; ill = !(opc inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd2}); end
      2: begin srca = 1; srcb = 2'b10; end
      3: begin mrd = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iord = 1; end
      6: begin srca = 1; op = 2'b10; end
      7: begin rw = 1; rdst = 1; end
      8: begin srca = 1; op = 2'b01; pcwc = 1; pcs = 2'b01; end
      9: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {op, srca, srcb, iord, mrd, mwr, irw, m2r, rdst, rw, pcs, pcw, pcwc, pcw | (pcwc & z), ill};
  endfunction

  // Runs one instruction from FETCH back to FETCH; memory stalls either random or scripted.
  task automatic run_instr(input logic [5:0] opc, input int f_stall, input int m_stall,
                           input int zmode, input bit rnd, output int cyc, output int pcw_n,
                           output int mw_n, output int rw_n);
    int p[$];
    int idx, fw, mw, es;
    bit seen;
    logic [17:0] e;
    case (opc)
      6'd35:   p = '{0, 1, 2, 3, 4};
      6'd43:   p = '{0, 1, 2, 5};
      6'd0:    p = '{0, 1, 6, 7};
      6'd4:    p = '{0, 1, 8};
      6'd2:    p = '{0, 1, 9};
      default: p = '{0, 1};
    endcase
    opcode = opc;
    idx = 0; fw = 0; mw = 0; seen = 0; cyc = 0; pcw_n = 0; mw_n = 0; rw_n = 0;
    while (1) begin
      @(negedge clk);
      es = (idx < p.size()) ? p[idx] : 0;
      if (rnd) mem_ready = ($urandom_range(0, 3) != 0);
      else if (es == 0) mem_ready = (fw >= f_stall);
      else if (es == 3 || es == 5) mem_ready = (mw >= m_stall);
      else mem_ready = 1'($urandom_range(0, 1));
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      #1;
      total++;
      if (state !== es[3:0]) $display("FAIL state opc=%h got %0d exp %0d", opc, state, es);
      else passed++;
      e = exp_out(es, mem_ready, zero, opc);
      total++;
      if (dut_out !== e) $display("FAIL outputs opc=%h st=%0d got %h exp %h", opc, es, dut_out, e);
      else passed++;
      pcw_n += int'(PCWrite); mw_n += int'(MemWrite); rw_n += int'(RegWrite);
      if ((es == 0 || es == 3 || es == 5) && !mem_ready) begin
        if (es == 0) fw++; else mw++;
      end else idx++;
      @(posedge clk); #1;
      cyc++;
      if (state != 4'd0) seen = 1;
      else if (seen) break;
      if (cyc > 60) begin
        total++;
        $display("FAIL timeout opc=%h got %0d cycles exp <=60", opc, cyc);
        break;
      end
    end
    total++;
    if (idx != p.size()) $display("FAIL length opc=%h got %0d steps exp %0d", opc, idx, p.size());
    else passed++;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (dut_out !== 18'd0 || state !== 4'd0) $display("FAIL reset got %h/%0d exp 0/0", dut_out, state);
    else passed++;
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    total++;
    if (MemRead !== 1'b1 || state !== 4'd0) $display("FAIL reset_release got MemRead=%b st=%0d exp 1/0", MemRead, state);
    else passed++;
  endtask

  task automatic test_directed;
    logic [5:0] ops[6] = '{6'd35, 6'd43, 6'd0, 6'd4, 6'd2, 6'h3f};
    int len[6] = '{5, 4, 4, 3, 3, 2};
    int rws[6] = '{1, 0, 1, 0, 0, 0};
    int mws[6] = '{0, 1, 0, 0, 0, 0};
    int pcws[6] = '{1, 1, 1, 1, 2, 1};
    int cyc, pcw, mw, rw;
    for (int i = 0; i < 6; i++) begin
      run_instr(ops[i], 0, 0, 1, 0, cyc, pcw, mw, rw);
      total++;
      if (cyc != len[i] || rw != rws[i] || mw != mws[i] || pcw != pcws[i])
        $display("FAIL directed opc=%h got cyc=%0d rw=%0d mw=%0d pcw=%0d exp %0d/%0d/%0d/%0d",
                 ops[i], cyc, rw, mw, pcw, len[i], rws[i], mws[i], pcws[i]);
      else passed++;
    end
    run_instr(6'd4, 0, 0, 0, 0, cyc, pcw, mw, rw);
  endtask

  task automatic test_sw_stall;
    int cyc, pcw, mw, rw;
    run_instr(6'd43, 3, 2, 2, 0, cyc, pcw, mw, rw);
    total++;
    if (cyc != 9 || pcw != 1 || mw != 3 || rw != 0)
      $display("FAIL sw_stall got cyc=%0d pcw=%0d mw=%0d rw=%0d exp 9/1/3/0", cyc, pcw, mw, rw);
    else passed++;
  endtask

  task automatic test_reset_mid_memwrite;
    opcode = 6'd43;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state == 4'd5) break;
      mem_ready = 1'b1;
    end
    mem_ready = 1'b0;
    #1;
    total++;
    if (state !== 4'd5 || MemWrite !== 1'b1) $display("FAIL reach_memwrite got st=%0d exp 5", state);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dut_out !== 18'd0 || state !== 4'd0) $display("FAIL async_reset got %h/%0d exp 0/0", dut_out, state);
    else passed++;
    repeat (2) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      total++;
      if (dut_out !== 18'd0 || state !== 4'd0) $display("FAIL hold_reset got %h/%0d exp 0/0", dut_out, state);
      else passed++;
    end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || dut_out !== exp_out(0, 1'b0, zero, opcode))
      $display("FAIL after_reset got %h/%0d exp %h/0", dut_out, state, exp_out(0, 1'b0, zero, opcode));
    else passed++;
  endtask

  task automatic test_random;
    logic [5:0] legal[5] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2};
    logic [5:0] opc;
    int r, cyc, pcw, mw, rw;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 5);
      opc = (r < 5) ? legal[r] : 6'($urandom);
      run_instr(opc, 0, 0, 2, 1, cyc, pcw, mw, rw);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_sw_stall;
    test_reset_mid_memwrite;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
